// File: rtl/eth_pkg.sv
// Shared types for the Ethernet receive path: write-FSM states, the 9-bit
// buffered beat and the statistics counter width with a saturating increment.
package eth_pkg;

   localparam int ETH_STAT_W = 32;

   typedef enum logic {WR_PASS, WR_DROP} eth_rxf_wr_state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } eth_byte_beat_t;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [ETH_STAT_W-1:0] sat_inc(input logic [ETH_STAT_W-1:0] v);
      return (&v) ? v : v + {{(ETH_STAT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// Byte-wide AXI-Stream link with a bad-frame flag on tuser.
interface eth_rx_frame_fifo_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module eth_sdp_ram #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2048,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO between the MAC and the frame parser.
// Frames are released only once they end good; bad or overflowing frames are
// rolled back whole. Optional statistics counters: ETH_RX_FIFO_STATS_EN.
module eth_rx_frame_fifo
   import eth_pkg::*;
#(
   parameter int DEPTH = 2048,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   eth_rx_frame_fifo_if.slave    s_axis,
   eth_rx_frame_fifo_if.master   m_axis,
   output logic                  drop_pulse,
   output logic [ADDR_W:0]       fifo_level
`ifdef ETH_RX_FIFO_STATS_EN
   ,
   output logic [ETH_STAT_W-1:0] stat_good_frames,
   output logic [ETH_STAT_W-1:0] stat_bad_fcs,
   output logic [ETH_STAT_W-1:0] stat_overflow
`endif
);

   localparam logic [ADDR_W:0] DEPTH_PTR = (ADDR_W+1)'(DEPTH);

   eth_rxf_wr_state_t wr_state_reg, wr_state_next;
   logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W:0]   wr_commit_reg, wr_commit_next;
   logic [ADDR_W:0]   rd_ptr_reg;      // bytes handed to the parser
   logic [ADDR_W:0]   fetch_ptr_reg;   // next RAM address to read
   logic [ADDR_W:0]   fifo_level_reg;
   logic              s_ready_reg;
   logic              drop_pulse_reg, drop_next;
   logic              accept, full, ram_we;
   logic              rd_issue, push, pop;
   logic              ram_vld_reg;
   logic [8:0]        ram_rd_data;
   eth_byte_beat_t    wr_beat, rd_beat;
   logic [1:0]        skid_cnt_reg, skid_cnt_next;
   eth_byte_beat_t    skid0_reg, skid0_next, skid1_reg, skid1_next;
   logic [2:0]        occ_after_pop;

   assign accept  = s_axis.tvalid & s_ready_reg;
   // Space is freed only when the parser actually takes a byte
   assign full    = (wr_ptr_reg - rd_ptr_reg) == DEPTH_PTR;
   assign wr_beat = {s_axis.tlast, s_axis.tdata};
   assign rd_beat = eth_byte_beat_t'(ram_rd_data);

   eth_sdp_ram #(
      .WIDTH ($bits(eth_byte_beat_t)),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
      .wr_data (wr_beat),
      .rd_en   (rd_issue),
      .rd_addr (fetch_ptr_reg[ADDR_W-1:0]),
      .rd_data (ram_rd_data)
   );

   // Write FSM: speculative write, commit on good tlast, rollback on bad/overflow
   always_comb begin
      wr_state_next  = wr_state_reg;
      wr_ptr_next    = wr_ptr_reg;
      wr_commit_next = wr_commit_reg;
      ram_we         = 1'b0;
      drop_next      = 1'b0;
      if (accept) begin
         case (wr_state_reg)
            WR_PASS: begin
               if (full) begin
                  wr_ptr_next = wr_commit_reg;
                  drop_next   = 1'b1;
                  if (!s_axis.tlast) wr_state_next = WR_DROP;
               end else begin
                  ram_we      = 1'b1;
                  wr_ptr_next = wr_ptr_reg + 1'b1;
                  if (s_axis.tlast) begin
                     if (s_axis.tuser) begin
                        wr_ptr_next = wr_commit_reg;
                        drop_next   = 1'b1;
                     end else begin
                        wr_commit_next = wr_ptr_reg + 1'b1;
                     end
                  end
               end
            end
            WR_DROP: begin
               if (s_axis.tlast) wr_state_next = WR_PASS;
            end
            default: wr_state_next = WR_PASS;
         endcase
      end
   end

   // Write-side state and MAC-facing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_reg   <= WR_PASS;
         wr_ptr_reg     <= '0;
         wr_commit_reg  <= '0;
         s_ready_reg    <= 1'b0;
         drop_pulse_reg <= 1'b0;
      end else begin
         wr_state_reg   <= wr_state_next;
         wr_ptr_reg     <= wr_ptr_next;
         wr_commit_reg  <= wr_commit_next;
         s_ready_reg    <= 1'b1;
         drop_pulse_reg <= drop_next;
      end
   end

   // Fetch a committed byte whenever the RAM stage plus skid will have room
   assign pop           = (skid_cnt_reg != 2'd0) & m_axis.tready;
   assign push          = ram_vld_reg;
   assign occ_after_pop = {1'b0, skid_cnt_reg} + {2'b0, ram_vld_reg} - {2'b0, pop};
   assign rd_issue      = (fetch_ptr_reg != wr_commit_reg) && (occ_after_pop < 3'd2);

   // Two-entry output skid; entry 0 drives the downstream port
   always_comb begin
      skid0_next    = skid0_reg;
      skid1_next    = skid1_reg;
      skid_cnt_next = skid_cnt_reg + {1'b0, push} - {1'b0, pop};
      if (pop) skid0_next = skid1_reg;
      if (push) begin
         if ((skid_cnt_reg - {1'b0, pop}) == 2'd0) skid0_next = rd_beat;
         else                                      skid1_next = rd_beat;
      end
   end

   // Read-side pointers, skid storage and the level report
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg     <= '0;
         fetch_ptr_reg  <= '0;
         ram_vld_reg    <= 1'b0;
         skid_cnt_reg   <= 2'd0;
         skid0_reg      <= '0;
         skid1_reg      <= '0;
         fifo_level_reg <= '0;
      end else begin
         rd_ptr_reg     <= rd_ptr_reg + {{ADDR_W{1'b0}}, pop};
         fetch_ptr_reg  <= fetch_ptr_reg + {{ADDR_W{1'b0}}, rd_issue};
         ram_vld_reg    <= rd_issue;
         skid_cnt_reg   <= skid_cnt_next;
         skid0_reg      <= skid0_next;
         skid1_reg      <= skid1_next;
         fifo_level_reg <= wr_commit_reg - rd_ptr_reg;
      end
   end

   assign s_axis.tready = s_ready_reg;
   assign m_axis.tvalid = (skid_cnt_reg != 2'd0);
   assign m_axis.tdata  = skid0_reg.data;
   assign m_axis.tlast  = skid0_reg.last;
   assign m_axis.tuser  = 1'b0;
   assign drop_pulse    = drop_pulse_reg;
   assign fifo_level    = fifo_level_reg;

`ifdef ETH_RX_FIFO_STATS_EN
   // Per-frame event counters: commits, bad-FCS drops, overflow drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_good_frames <= '0;
         stat_bad_fcs     <= '0;
         stat_overflow    <= '0;
      end else if (accept && wr_state_reg == WR_PASS) begin
         if (full)
            stat_overflow <= sat_inc(stat_overflow);
         else if (s_axis.tlast && s_axis.tuser)
            stat_bad_fcs <= sat_inc(stat_bad_fcs);
         else if (s_axis.tlast)
            stat_good_frames <= sat_inc(stat_good_frames);
      end
   end
`endif

endmodule
